// File: rtl/p2s_pkg.sv
// Shared encodings for the p2s_tx parallel-to-serial frame transmitter.
package p2s_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;

   // Bit order on the serial line; must match the downstream register's DIR.
   localparam logic MSB_FIRST = 1'b0;
   localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/p2s_fifo2.sv
// Two-entry word buffer between the valid/ready port and the frame engine.
module p2s_fifo2 #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST_L,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (count_q == 2'd2);
   assign empty_o = (count_q == 2'd0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rd_ptr_q];

   always_ff @(posedge CLK or negedge RST_L) begin
      if (!RST_L) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_ok) wr_ptr_q <= ~wr_ptr_q;
         if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: storage has no reset; the count and pointers alone decide which entries are valid.
   always_ff @(posedge CLK) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/p2s_tx.sv
// Frame engine: START, WIDTH data bits, optional even parity, STOP, all from registered outputs.
module p2s_tx
   import p2s_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST_L,
   input  logic [WIDTH-1:0] D_IN,
   input  logic             VALID_IN,
   output logic             READY_OUT,
   input  logic             DIR,
   input  logic             PAR_EN,
   output logic             S_OUT,
   output logic             ENB_OUT,
   output logic             BUSY,
   output logic             FRAME_DONE
);

   localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             par_en_q, par_en_d;
   logic             parity_q, parity_d;
   logic             s_out_q, s_out_d;
   logic             enb_q, enb_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_rdata;
   logic             load;
   logic             cur_bit;

   p2s_fifo2 #(.WIDTH(WIDTH)) u_fifo (
      .CLK     (CLK),
      .RST_L   (RST_L),
      .push_i  (VALID_IN),
      .wdata_i (D_IN),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign READY_OUT  = ~fifo_full;
   assign S_OUT      = s_out_q;
   assign ENB_OUT    = enb_q;
   assign BUSY       = busy_q;
   assign FRAME_DONE = done_q;

   // The shift register always presents the next bit at the end selected by the latched DIR.
   assign cur_bit = (dir_q == LSB_FIRST) ? shift_q[0] : shift_q[WIDTH-1];

   // NOTE: every variable gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      dir_d    = dir_q;
      par_en_d = par_en_q;
      parity_d = parity_q;
      s_out_d  = 1'b1;
      enb_d    = 1'b0;
      done_d   = 1'b0;
      load     = 1'b0;
      fifo_pop = 1'b0;

      unique case (state_q)
         IDLE:   load = ~fifo_empty;
         START: begin
            s_out_d = 1'b0;
            cnt_d   = '0;
            state_d = DATA;
         end
         DATA: begin
            s_out_d  = cur_bit;
            enb_d    = 1'b1;
            parity_d = parity_q ^ cur_bit;
            shift_d  = (dir_q == LSB_FIRST) ? (shift_q >> 1) : (shift_q << 1);
            if (cnt_q == LAST_BIT) begin
               cnt_d   = '0;
               state_d = par_en_q ? PARITY : STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PARITY: begin
            s_out_d = parity_q;
            state_d = STOP;
         end
         STOP: begin
            done_d  = 1'b1;
            load    = ~fifo_empty;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Frame start from IDLE or straight out of STOP, so queued words run with no gap.
      if (load) begin
         fifo_pop = 1'b1;
         shift_d  = fifo_rdata;
         dir_d    = DIR;
         par_en_d = PAR_EN;
         parity_d = 1'b0;
         state_d  = START;
      end

      busy_d = (state_q != IDLE) | ~fifo_empty;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge CLK or negedge RST_L) begin
      if (!RST_L) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         cnt_q    <= '0;
         dir_q    <= MSB_FIRST;
         par_en_q <= 1'b0;
         parity_q <= 1'b0;
         s_out_q  <= 1'b1;
         enb_q    <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
         dir_q    <= dir_d;
         par_en_q <= par_en_d;
         parity_q <= parity_d;
         s_out_q  <= s_out_d;
         enb_q    <= enb_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

endmodule

// File: tb/tb_p2s_tx.sv
// Scoreboard bench for p2s_tx: expected frames queued at push, observed frames rebuilt by a line monitor.
module tb_p2s_tx;

   localparam int W = 8;

   logic         CLK = 1'b0;
   logic         RST_L = 1'b0;
   logic [W-1:0] D_IN = '0;
   logic         VALID_IN = 1'b0;
   logic         DIR = 1'b0;
   logic         PAR_EN = 1'b0;
   logic         READY_OUT;
   logic         S_OUT;
   logic         ENB_OUT;
   logic         BUSY;
   logic         FRAME_DONE;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   p2s_tx #(.WIDTH(W)) dut (
      .CLK        (CLK),
      .RST_L      (RST_L),
      .D_IN       (D_IN),
      .VALID_IN   (VALID_IN),
      .READY_OUT  (READY_OUT),
      .DIR        (DIR),
      .PAR_EN     (PAR_EN),
      .S_OUT      (S_OUT),
      .ENB_OUT    (ENB_OUT),
      .BUSY       (BUSY),
      .FRAME_DONE (FRAME_DONE)
   );

   typedef struct packed {
      logic [W-1:0] bits;      // downstream PUSH register view, first bit ends up at the MSB
      logic [7:0]   nbits;
      logic         par_seen;
      logic         par_bit;
      logic         stop_bit;
      logic         done;
      logic [7:0]   len;
   } frame_t;

   frame_t exp_q[$];
   frame_t obs_q[$];
   int     gap_q[$];

   function automatic frame_t expect_frame(logic [W-1:0] d, logic dir, logic par);
      frame_t f;
      f = '0;
      for (int i = 0; i < W; i++) f.bits[i] = dir ? d[W-1-i] : d[i];
      f.nbits    = 8'(W);
      f.par_seen = par;
      f.par_bit  = par & (^d);
      f.stop_bit = 1'b1;
      f.done     = 1'b1;
      f.len      = 8'(W + 2 + (par ? 1 : 0));
      return f;
   endfunction

   function automatic string fmt(frame_t f);
      return $sformatf("bits=%h nbits=%0d par_seen=%b par=%b stop=%b done=%b len=%0d",
                       f.bits, f.nbits, f.par_seen, f.par_bit, f.stop_bit, f.done, f.len);
   endfunction

   // Line monitor: rebuilds frames from S_OUT/ENB_OUT/FRAME_DONE, sampled on the falling edge.
   frame_t cur;
   int     in_frame = 0;
   int     gap = -1;
   int     cur_gap = -1;
   int     done_count = 0;

   always @(negedge CLK) begin
      if (!RST_L) begin
         in_frame = 0;
         gap = -1;
      end else begin
         if (FRAME_DONE === 1'b1) done_count++;
         if (in_frame == 0) begin
            if (S_OUT === 1'b0) begin
               in_frame = 1;
               cur = '0;
               cur.len = 8'd1;
               cur_gap = gap;
            end else if (gap >= 0) begin
               gap++;
            end
         end else begin
            cur.len = cur.len + 8'd1;
            if (ENB_OUT === 1'b1 && cur.len < 8'(W + 3)) begin
               cur.bits  = {cur.bits[W-2:0], S_OUT};
               cur.nbits = cur.nbits + 8'd1;
            end else if (FRAME_DONE === 1'b1 || cur.len >= 8'(W + 3)) begin
               cur.stop_bit = S_OUT;
               cur.done     = FRAME_DONE;
               obs_q.push_back(cur);
               gap_q.push_back(cur_gap);
               in_frame = 0;
               gap = 0;
            end else begin
               cur.par_seen = 1'b1;
               cur.par_bit  = S_OUT;
            end
         end
      end
   end

   // Called and returning at #1 after a rising edge; leaves VALID_IN high when hold is set.
   task automatic push_word(input logic [W-1:0] d, input bit hold);
      int n;
      n = 0;
      D_IN = d;
      VALID_IN = 1'b1;
      while (READY_OUT !== 1'b1 && n < 100) begin
         @(posedge CLK); #1;
         n++;
      end
      if (n >= 100) begin
         n_checks++; n_errors++;
         $display("FAIL push_ready_timeout: READY_OUT=%b after %0d cycles, want 1", READY_OUT, n);
      end
      @(posedge CLK);
      exp_q.push_back(expect_frame(d, DIR, PAR_EN));
      #1;
      if (!hold) VALID_IN = 1'b0;
   endtask

   task automatic get_frame(output frame_t o, output frame_t e, output int g, output bit ok);
      int n;
      n = 0;
      o = '0; e = '0; g = -1; ok = 1'b0;
      while (obs_q.size() == 0 && n < 400) begin
         @(posedge CLK); #1;
         n++;
      end
      if (obs_q.size() == 0 || exp_q.size() == 0) begin
         n_checks++; n_errors++;
         $display("FAIL frame_timeout: observed=%0d expected=%0d queued after %0d cycles, want a frame",
                  obs_q.size(), exp_q.size(), n);
      end else begin
         o = obs_q.pop_front();
         g = gap_q.pop_front();
         e = exp_q.pop_front();
         ok = 1'b1;
      end
   endtask

   task automatic wait_enb(input string name);
      int n;
      n = 0;
      while (ENB_OUT !== 1'b1 && n < 50) begin
         @(posedge CLK); #1;
         n++;
      end
      n_checks++;
      if (ENB_OUT !== 1'b1) begin
         n_errors++;
         $display("FAIL %s: ENB_OUT=%b after %0d cycles, want 1", name, ENB_OUT, n);
      end
   endtask

   task automatic test_reset();
      RST_L = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      n_checks++; if (S_OUT !== 1'b1)      begin n_errors++; $display("FAIL reset_s_out: got %b want 1", S_OUT); end
      n_checks++; if (ENB_OUT !== 1'b0)    begin n_errors++; $display("FAIL reset_enb: got %b want 0", ENB_OUT); end
      n_checks++; if (READY_OUT !== 1'b1)  begin n_errors++; $display("FAIL reset_ready: got %b want 1", READY_OUT); end
      n_checks++; if (BUSY !== 1'b0)       begin n_errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
      n_checks++; if (FRAME_DONE !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", FRAME_DONE); end
      RST_L = 1'b1;
      @(posedge CLK); #1;
   endtask

   task automatic test_msb_first();
      logic [9:0] seq, enb_mask, done_mask;
      frame_t o, e;
      int g;
      bit ok;
      DIR = 1'b0; PAR_EN = 1'b0;
      D_IN = 8'hA5; VALID_IN = 1'b1;
      @(posedge CLK);
      exp_q.push_back(expect_frame(8'hA5, DIR, PAR_EN));
      #1; VALID_IN = 1'b0;
      @(posedge CLK); #1;
      n_checks++;
      if (S_OUT !== 1'b1) begin n_errors++; $display("FAIL latency_t1_idle: S_OUT=%b want 1", S_OUT); end
      @(posedge CLK); #1;
      seq = '0; enb_mask = '0; done_mask = '0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) begin @(posedge CLK); #1; end
         seq       = {seq[8:0], S_OUT};
         enb_mask  = {enb_mask[8:0], ENB_OUT};
         done_mask = {done_mask[8:0], FRAME_DONE};
      end
      n_checks++;
      if (seq !== 10'b0101001011) begin n_errors++; $display("FAIL a5_sequence: got %b want 0101001011", seq); end
      n_checks++;
      if (enb_mask !== 10'b0111111110) begin n_errors++; $display("FAIL a5_enb: got %b want 0111111110", enb_mask); end
      n_checks++;
      if (done_mask !== 10'b0000000001) begin n_errors++; $display("FAIL a5_done: got %b want 0000000001", done_mask); end
      get_frame(o, e, g, ok);
      if (ok) begin
         n_checks++;
         if (o !== e) begin n_errors++; $display("FAIL a5_frame: got %s want %s", fmt(o), fmt(e)); end
      end
   endtask

   task automatic test_lsb_parity();
      frame_t o, e;
      int g;
      bit ok;
      DIR = 1'b1; PAR_EN = 1'b1;
      push_word(8'h01, 1'b0);
      get_frame(o, e, g, ok);
      if (ok) begin
         n_checks++;
         if (o !== e) begin n_errors++; $display("FAIL lsb_par_frame: got %s want %s", fmt(o), fmt(e)); end
      end
      DIR = 1'b0; PAR_EN = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] words [3];
      frame_t o, e;
      int g;
      bit ok;
      words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
      DIR = 1'b0; PAR_EN = 1'b0;
      for (int i = 0; i < 3; i++) push_word(words[i], 1'b1);
      n_checks++;
      if (READY_OUT !== 1'b0) begin n_errors++; $display("FAIL b2b_ready_full: got %b want 0", READY_OUT); end
      VALID_IN = 1'b0;
      for (int i = 0; i < 3; i++) begin
         get_frame(o, e, g, ok);
         if (ok) begin
            n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL b2b_frame%0d: got %s want %s", i, fmt(o), fmt(e)); end
            if (i > 0) begin
               n_checks++;
               if (g !== 0) begin n_errors++; $display("FAIL b2b_gap%0d: got %0d idle cycles want 0", i, g); end
            end
         end
      end
      n_checks++;
      if (READY_OUT !== 1'b1) begin n_errors++; $display("FAIL b2b_ready_after: got %b want 1", READY_OUT); end
   endtask

   task automatic test_mid_frame_toggle();
      frame_t o, e;
      int g;
      bit ok;
      DIR = 1'b0; PAR_EN = 1'b0;
      push_word(8'hC3, 1'b0);
      wait_enb("toggle_enb_timeout");
      repeat (2) begin @(posedge CLK); #1; end
      DIR = 1'b1; PAR_EN = 1'b1;
      push_word(8'h5A, 1'b0);
      for (int i = 0; i < 2; i++) begin
         get_frame(o, e, g, ok);
         if (ok) begin
            n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL toggle_frame%0d: got %s want %s", i, fmt(o), fmt(e)); end
            if (i == 1) begin
               n_checks++;
               if (g !== 0) begin n_errors++; $display("FAIL toggle_gap: got %0d idle cycles want 0", g); end
            end
         end
      end
      DIR = 1'b0; PAR_EN = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      int dc;
      DIR = 1'b0; PAR_EN = 1'b0;
      push_word(8'h3C, 1'b1);
      push_word(8'h96, 1'b0);
      wait_enb("abort_enb_timeout");
      repeat (3) begin @(posedge CLK); #1; end
      dc = done_count;
      RST_L = 1'b0;
      #1;
      n_checks++; if (S_OUT !== 1'b1)      begin n_errors++; $display("FAIL abort_s_out: got %b want 1", S_OUT); end
      n_checks++; if (ENB_OUT !== 1'b0)    begin n_errors++; $display("FAIL abort_enb: got %b want 0", ENB_OUT); end
      n_checks++; if (READY_OUT !== 1'b1)  begin n_errors++; $display("FAIL abort_ready: got %b want 1", READY_OUT); end
      n_checks++; if (BUSY !== 1'b0)       begin n_errors++; $display("FAIL abort_busy: got %b want 0", BUSY); end
      n_checks++; if (FRAME_DONE !== 1'b0) begin n_errors++; $display("FAIL abort_done: got %b want 0", FRAME_DONE); end
      repeat (2) @(posedge CLK);
      #1;
      RST_L = 1'b1;
      exp_q.delete();
      repeat (30) begin @(posedge CLK); #1; end
      n_checks++;
      if (done_count !== dc) begin n_errors++; $display("FAIL abort_no_done: got %0d pulses want %0d", done_count, dc); end
      n_checks++;
      if (obs_q.size() !== 0) begin n_errors++; $display("FAIL abort_discard: got %0d frames want 0", obs_q.size()); end
      n_checks++;
      if (BUSY !== 1'b0) begin n_errors++; $display("FAIL abort_idle_busy: got %b want 0", BUSY); end
      obs_q.delete();
      gap_q.delete();
   endtask

   task automatic test_parity_edges();
      frame_t o, e;
      int g;
      bit ok;
      DIR = 1'b0; PAR_EN = 1'b1;
      push_word(8'hFF, 1'b1);
      push_word(8'h00, 1'b0);
      for (int i = 0; i < 2; i++) begin
         get_frame(o, e, g, ok);
         if (ok) begin
            n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL parity_frame%0d: got %s want %s", i, fmt(o), fmt(e)); end
         end
      end
      PAR_EN = 1'b0;
      repeat (5) begin @(posedge CLK); #1; end
      n_checks++;
      if (BUSY !== 1'b0) begin n_errors++; $display("FAIL final_busy: got %b want 0", BUSY); end
      n_checks++;
      if (READY_OUT !== 1'b1) begin n_errors++; $display("FAIL final_ready: got %b want 1", READY_OUT); end
   endtask

   initial begin
      test_reset();
      test_msb_first();
      test_lsb_parity();
      test_back_to_back();
      test_mid_frame_toggle();
      test_reset_mid_frame();
      test_parity_edges();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

endmodule
